// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcode map, control bundle types and the pure opcode decoder
package decode_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_LDR  = 5'b00100;
  localparam logic [4:0] OP_STR  = 5'b00101;
  localparam logic [4:0] OP_FADD = 5'b01000;
  localparam logic [4:0] OP_FSUB = 5'b01001;
  localparam logic [4:0] OP_FMUL = 5'b01010;
  localparam logic [4:0] OP_FLDR = 5'b01100;
  localparam logic [4:0] OP_FSTR = 5'b01101;
  localparam logic [4:0] OP_BEQ  = 5'b11100;
  localparam logic [4:0] OP_B    = 5'b11101;
  localparam logic [4:0] OP_NOP  = 5'b11111;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       reg_write;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       branch_uncond;
    logic       fp_op;
    logic       integer_op;
  } ctrl_t;

  typedef enum logic {RUN = 1'b0, FP_WAIT = 1'b1} state_t;

  typedef struct packed {
    ctrl_t ctrl;
    logic  illegal;
    logic  reads_src;
  } decode_t;

  function automatic decode_t decode_op(input logic [4:0] op);
    decode_t d;
    d = '0;
    d.reads_src = 1'b1;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        d.ctrl.alu_op     = {2'b00, op[1:0]};
        d.ctrl.reg_write  = 1'b1;
        d.ctrl.integer_op = 1'b1;
      end
      OP_LDR, OP_FLDR: begin
        d.ctrl.alu_src    = 1'b1;
        d.ctrl.mem_read   = 1'b1;
        d.ctrl.mem_to_reg = 1'b1;
        d.ctrl.reg_write  = 1'b1;
        d.ctrl.fp_op      = op[3];
        d.ctrl.integer_op = ~op[3];
      end
      OP_STR, OP_FSTR: begin
        d.ctrl.alu_src    = 1'b1;
        d.ctrl.mem_write  = 1'b1;
        d.ctrl.fp_op      = op[3];
        d.ctrl.integer_op = ~op[3];
      end
      OP_FADD, OP_FSUB, OP_FMUL: begin
        d.ctrl.alu_op    = {2'b10, op[1:0]};
        d.ctrl.fp_op     = 1'b1;
        d.ctrl.reg_write = 1'b1;
      end
      OP_BEQ: begin
        d.ctrl.alu_op = 4'b0001;
        d.ctrl.branch = 1'b1;
      end
      OP_B: begin
        d.ctrl.branch        = 1'b1;
        d.ctrl.branch_uncond = 1'b1;
        d.reads_src          = 1'b0;
      end
      OP_NOP: d.reads_src = 1'b0;
      default: begin
        d.illegal   = 1'b1;
        d.reads_src = 1'b0;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// rtl/decode_comb.sv - combinational opcode decoder, reusable by other stages
module decode_comb
  import decode_pkg::*;
(
  input  logic [4:0] i_opcode,
  output ctrl_t      o_ctrl,
  output logic       o_illegal,
  output logic       o_reads_src
);

  decode_t w_dec;

  assign w_dec       = decode_op(i_opcode);
  assign o_ctrl      = w_dec.ctrl;
  assign o_illegal   = w_dec.illegal;
  assign o_reads_src = w_dec.reads_src;

endmodule

// File: rtl/decode_ctrl_pipe.sv
// rtl/decode_ctrl_pipe.sv - registered decode stage with load-use bubble, float
// occupancy blocking and branch flush, driving the ID/EX register
module decode_ctrl_pipe
  import decode_pkg::*;
#(
  parameter int REGW     = 4,
  parameter int FP_LAT   = 3,
  parameter int FP_CNT_W = $clog2(FP_LAT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      opcode,
  input  logic [REGW-1:0] rs1,
  input  logic [REGW-1:0] rs2,
  input  logic [REGW-1:0] rd,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            out_valid,
  output ctrl_t           out_ctrl,
  output logic [REGW-1:0] out_rs1,
  output logic [REGW-1:0] out_rs2,
  output logic [REGW-1:0] out_rd,
  output logic            out_illegal
);

  ctrl_t             w_ctrl;
  logic              w_illegal;
  logic              w_reads_src;
  logic              w_hazard;
  logic              w_accept;
  logic              w_issue;
  logic              w_issue_ld;
  logic              w_issue_fp;

  logic              r_out_valid;
  ctrl_t             r_out_ctrl;
  logic [REGW-1:0]   r_out_rs1;
  logic [REGW-1:0]   r_out_rs2;
  logic [REGW-1:0]   r_out_rd;
  logic              r_out_illegal;
  state_t            r_state;
  logic [FP_CNT_W-1:0] r_fp_cnt;
  logic              r_ld_v;
  logic [REGW-1:0]   r_ld_rd;

  decode_comb u_dec (
    .i_opcode    (opcode),
    .o_ctrl      (w_ctrl),
    .o_illegal   (w_illegal),
    .o_reads_src (w_reads_src)
  );

  assign w_hazard = r_ld_v & in_valid & w_reads_src &
                    ((rs1 == r_ld_rd) | (rs2 == r_ld_rd));
  assign in_ready = (r_state == RUN) & (~r_out_valid | ex_ready) &
                    ~w_hazard & ~flush & ~rst;
  assign w_accept = in_valid & in_ready;
  assign w_issue  = r_out_valid & ex_ready;
  assign w_issue_ld = w_issue & r_out_ctrl.mem_read & r_out_ctrl.reg_write;
  // Float arithmetic only; float loads/stores do not occupy the FP unit
  assign w_issue_fp = w_issue & r_out_ctrl.fp_op &
                      ~r_out_ctrl.mem_read & ~r_out_ctrl.mem_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_ctrl    <= '0;
      r_out_rs1     <= '0;
      r_out_rs2     <= '0;
      r_out_rd      <= '0;
      r_out_illegal <= 1'b0;
      r_state       <= RUN;
      r_fp_cnt      <= '0;
      r_ld_v        <= 1'b0;
      r_ld_rd       <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_state     <= RUN;
      r_fp_cnt    <= '0;
      r_ld_v      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_out_valid   <= 1'b1;
        r_out_ctrl    <= w_ctrl;
        r_out_rs1     <= rs1;
        r_out_rs2     <= rs2;
        r_out_rd      <= rd;
        r_out_illegal <= w_illegal;
      end else if (w_issue) begin
        r_out_valid <= 1'b0;
      end

      r_ld_v <= w_issue_ld;
      if (w_issue_ld) r_ld_rd <= r_out_rd;

      case (r_state)
        RUN: begin
          if (w_issue_fp && FP_LAT > 1) begin
            r_state  <= FP_WAIT;
            r_fp_cnt <= FP_CNT_W'(FP_LAT - 1);
          end
        end
        FP_WAIT: begin
          r_fp_cnt <= r_fp_cnt - FP_CNT_W'(1);
          if (r_fp_cnt == FP_CNT_W'(1)) r_state <= RUN;
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign out_valid   = r_out_valid;
  assign out_ctrl    = r_out_ctrl;
  assign out_rs1     = r_out_rs1;
  assign out_rs2     = r_out_rs2;
  assign out_rd      = r_out_rd;
  assign out_illegal = r_out_illegal;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// tb/tb_decode_ctrl_pipe.sv - directed self-checking bench for decode_ctrl_pipe
module tb_decode_ctrl_pipe;

  localparam logic [12:0] C_ADD  = 13'b0000_100000001;
  localparam logic [12:0] C_SUB  = 13'b0001_100000001;
  localparam logic [12:0] C_LDR  = 13'b0000_111010001;
  localparam logic [12:0] C_STR  = 13'b0000_010100001;
  localparam logic [12:0] C_FADD = 13'b1000_100000010;
  localparam logic [12:0] C_FMUL = 13'b1010_100000010;
  localparam logic [12:0] C_BEQ  = 13'b0001_000001000;
  localparam logic [12:0] C_B    = 13'b0000_000001100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [4:0]  opcode = '0;
  logic [3:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic        flush = 1'b0;
  logic        ex_ready = 1'b1;

  logic        in_ready, out_valid, out_illegal;
  logic [12:0] out_ctrl;
  logic [3:0]  out_rs1, out_rs2, out_rd;

  logic        f1_in_ready, f1_out_valid, f1_out_illegal;
  logic [12:0] f1_out_ctrl;
  logic [3:0]  f1_out_rs1, f1_out_rs2, f1_out_rd;

  int n_tests = 0;
  int n_fail  = 0;

  decode_ctrl_pipe #(.REGW(4), .FP_LAT(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rs1(rs1), .rs2(rs2), .rd(rd), .flush(flush),
    .ex_ready(ex_ready), .out_valid(out_valid), .out_ctrl(out_ctrl),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_illegal(out_illegal)
  );

  decode_ctrl_pipe #(.REGW(4), .FP_LAT(1)) dut_f1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(f1_in_ready),
    .opcode(opcode), .rs1(rs1), .rs2(rs2), .rd(rd), .flush(flush),
    .ex_ready(ex_ready), .out_valid(f1_out_valid), .out_ctrl(f1_out_ctrl),
    .out_rs1(f1_out_rs1), .out_rs2(f1_out_rs2), .out_rd(f1_out_rd),
    .out_illegal(f1_out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [4:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] d);
    in_valid = 1'b1;
    opcode   = op;
    rs1      = a;
    rs2      = b;
    rd       = d;
  endtask

  initial begin
    #1;
    check("rst_in_ready", in_ready, 0);
    step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_out_illegal", out_illegal, 0);
    check("rst_out_rd", out_rd, 0);
    rst = 1'b0;

    // basic ADD
    present(5'b00000, 4'd1, 4'd2, 4'd3);
    #1 check("add_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("add_valid", out_valid, 1);
    check("add_ctrl", out_ctrl, C_ADD);
    check("add_rs1", out_rs1, 1);
    check("add_rs2", out_rs2, 2);
    check("add_rd", out_rd, 3);
    check("add_illegal", out_illegal, 0);
    step();
    check("add_issued", out_valid, 0);

    // back-to-back throughput
    present(5'b00001, 4'd1, 4'd2, 4'd4);
    step();
    check("sub_ctrl", out_ctrl, C_SUB);
    present(5'b00000, 4'd1, 4'd2, 4'd7);
    #1 check("tput_in_ready", in_ready, 1);
    step();
    check("tput_rd", out_rd, 7);
    check("tput_valid", out_valid, 1);
    in_valid = 1'b0;
    step();

    // load-use: dependent consumer right after LDR issue
    present(5'b00100, 4'd0, 4'd0, 4'd5);
    step();
    check("ldr_ctrl", out_ctrl, C_LDR);
    in_valid = 1'b0;
    step();
    present(5'b00000, 4'd5, 4'd0, 4'd8);
    #1 check("lu_bubble", in_ready, 0);
    step();
    check("lu_not_accepted", out_valid, 0);
    check("lu_ready_after", in_ready, 1);
    step();
    check("lu_rd", out_rd, 8);
    in_valid = 1'b0;
    step();

    // independent consumer: no bubble
    present(5'b00100, 4'd0, 4'd0, 4'd5);
    step();
    in_valid = 1'b0;
    step();
    present(5'b00000, 4'd6, 4'd0, 4'd9);
    #1 check("nodep_in_ready", in_ready, 1);
    step();
    check("nodep_rd", out_rd, 9);
    check("nodep_valid", out_valid, 1);
    in_valid = 1'b0;
    step();

    // float occupancy
    present(5'b01000, 4'd1, 4'd2, 4'd3);
    step();
    check("fadd_ctrl", out_ctrl, C_FADD);
    in_valid = 1'b0;
    step();
    check("fp_wait1", in_ready, 0);
    check("fp1_no_wait", f1_in_ready, 1);
    step();
    check("fp_wait2", in_ready, 0);
    step();
    check("fp_done", in_ready, 1);

    // backpressure
    present(5'b00001, 4'd1, 4'd2, 4'd10);
    step();
    ex_ready = 1'b0;
    present(5'b00000, 4'd3, 4'd4, 4'd11);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_hold_rd", out_rd, 10);
      check("bp_hold_ctrl", out_ctrl, C_SUB);
      step();
    end
    ex_ready = 1'b1;
    #1 check("bp_release_ready", in_ready, 1);
    step();
    check("bp_next_rd", out_rd, 11);
    in_valid = 1'b0;
    step();

    // flush during FP_WAIT
    present(5'b01010, 4'd1, 4'd2, 4'd12);
    step();
    check("fmul_ctrl", out_ctrl, C_FMUL);
    in_valid = 1'b0;
    step();
    present(5'b00000, 4'd1, 4'd2, 4'd13);
    flush = 1'b1;
    #1 check("flush_in_ready", in_ready, 0);
    step();
    flush = 1'b0;
    check("flush_valid", out_valid, 0);
    #1 check("flush_run", in_ready, 1);
    step();
    check("flush_then_rd", out_rd, 13);
    in_valid = 1'b0;
    step();

    // flush coincident with FADD issue: no FP_WAIT
    present(5'b01000, 4'd0, 4'd0, 4'd14);
    step();
    in_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1 check("flush_fp_ready", in_ready, 1);
    check("flush_fp_valid", out_valid, 0);

    // flush coincident with LDR issue: no load tag
    present(5'b00100, 4'd0, 4'd0, 4'd5);
    step();
    in_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    present(5'b00000, 4'd5, 4'd0, 4'd15);
    #1 check("flush_ld_ready", in_ready, 1);
    step();
    check("flush_ld_rd", out_rd, 15);

    // opcode corners
    present(5'b11111, 4'd0, 4'd0, 4'd1);
    step();
    check("nop_ctrl", out_ctrl, 0);
    check("nop_illegal", out_illegal, 0);
    check("nop_valid", out_valid, 1);
    present(5'b10110, 4'd0, 4'd0, 4'd2);
    step();
    check("ill_ctrl", out_ctrl, 0);
    check("ill_illegal", out_illegal, 1);
    check("ill_valid", out_valid, 1);
    check("ill_rd", out_rd, 2);
    present(5'b00101, 4'd1, 4'd2, 4'd0);
    step();
    check("str_ctrl", out_ctrl, C_STR);
    present(5'b11100, 4'd1, 4'd2, 4'd0);
    step();
    check("beq_ctrl", out_ctrl, C_BEQ);
    present(5'b11101, 4'd0, 4'd0, 4'd0);
    step();
    check("b_ctrl", out_ctrl, C_B);
    in_valid = 1'b0;
    step();

    // async reset mid FP_WAIT with a held instruction
    present(5'b01000, 4'd1, 4'd2, 4'd3);
    step();
    present(5'b00001, 4'd1, 4'd2, 4'd9);
    step();
    in_valid = 1'b0;
    ex_ready = 1'b0;
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_ready", in_ready, 0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ctrl", out_ctrl, 0);
    check("mid_rst_rd", out_rd, 0);
    check("mid_rst_ready", in_ready, 0);
    step();
    rst = 1'b0;
    ex_ready = 1'b1;
    #1 check("post_rst_ready", in_ready, 1);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
